// File: rtl/sub_serial_4bit.sv
// Bit-serial subtractor: one difference bit per clock, LSB first, under a start/busy/done handshake.
// Defining SUB_ZERO_FLAG_EN adds a registered zero output, updated together with diff/bout.
module sub_serial_4bit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH:0]   minuend,
    input  logic [WIDTH-1:0] subtrahend,
    input  logic             borrowin,
    output logic [WIDTH:0]   diff,
    output logic             bout,
    output logic             busy,
`ifdef SUB_ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic             done
);

    localparam int unsigned CW = ($clog2(WIDTH + 1) > 1) ? $clog2(WIDTH + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [WIDTH:0] m_q, m_d;
    logic [WIDTH:0] s_q, s_d;
    logic           b_q, b_d;
    logic [WIDTH:0] res_q, res_d;
    logic [WIDTH:0] diff_q, diff_d;
    logic           bout_q, bout_d;
`ifdef SUB_ZERO_FLAG_EN
    logic           zero_q, zero_d;
`endif

    logic           m_bit, s_bit, d_bit, b_next;

    // Operands shift right so the current bit is always at position 0;
    // result bits enter at the MSB and are fully aligned after WIDTH+1 shifts.
    always_comb begin
        m_bit  = m_q[0];
        s_bit  = s_q[0];
        d_bit  = m_bit ^ s_bit ^ b_q;
        b_next = (~m_bit & s_bit) | (~(m_bit ^ s_bit) & b_q);

        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        s_d     = s_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SUB_ZERO_FLAG_EN
        zero_d  = zero_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = minuend;
                    s_d     = {1'b0, subtrahend};
                    b_d     = borrowin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                m_d   = m_q >> 1;
                s_d   = s_q >> 1;
                b_d   = b_next;
                res_d = {d_bit, res_q[WIDTH:1]};
                if (cnt_q == CW'(WIDTH)) begin
                    cnt_d   = '0;
                    diff_d  = res_d;
                    bout_d  = b_next;
`ifdef SUB_ZERO_FLAG_EN
                    zero_d  = (res_d == '0) && !b_next;
`endif
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            s_q     <= '0;
            b_q     <= 1'b0;
            res_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SUB_ZERO_FLAG_EN
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            s_q     <= s_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SUB_ZERO_FLAG_EN
            zero_q  <= zero_d;
`endif
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
`ifdef SUB_ZERO_FLAG_EN
    assign zero = zero_q;
`endif

endmodule
